// File: rtl/frequency_meter.sv
// frequency_meter
//
// Measures the rate of an asynchronous input by counting its rising edges
// over a fixed gate window of SysClock cycles. Windows run back-to-back while
// Enable is high; each completed window updates Frequency/Overflow and pulses
// Valid for one cycle.
//
// Ports:
//   SysClock   in   sole clock, rising edge
//   Reset      in   synchronous, active-high; clears all state
//   Enable     in   high runs continuous windows, low returns to IDLE
//   SignalIn   in   asynchronous signal under measurement
//   Frequency  out  [COUNT_W] edge count of the last completed window (held)
//   Valid      out  one-cycle strobe when Frequency/Overflow update
//   Overflow   out  last completed window's count saturated
//   Busy       out  high while counting
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | not measuring; counters held at 0; results held
// COUNT | gate window running; rising edges accumulated

module frequency_meter #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int COUNT_W     = 24
) (
    input  logic               SysClock,
    input  logic               Reset,
    input  logic               Enable,
    input  logic               SignalIn,
    output logic [COUNT_W-1:0] Frequency,
    output logic               Valid,
    output logic               Overflow,
    output logic               Busy
);

    localparam int                  GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0]   GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [COUNT_W-1:0]  EDGE_MAX  = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t state, state_next;

    logic                s1, s2, s3;
    logic                sig_edge;
    logic [GATE_W-1:0]   gate_cnt;
    logic [COUNT_W-1:0]  edge_cnt;
    logic [COUNT_W-1:0]  edge_cnt_next;
    logic                sticky;
    logic                sticky_next;
    logic                edge_at_max;
    logic                window_end;

    // Two flops for metastability, a third to remember the previous level.
    assign sig_edge = s2 & ~s3;

    // Saturating edge count; the sticky bit records any increment lost at max.
    assign edge_at_max   = (edge_cnt == EDGE_MAX);
    assign edge_cnt_next = (sig_edge && !edge_at_max) ? edge_cnt + 1'b1 : edge_cnt;
    assign sticky_next   = sticky | (sig_edge & edge_at_max);
    assign window_end    = (state == COUNT) && (gate_cnt == GATE_LAST);

    always_ff @(posedge SysClock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Window end does not alter the next state: COUNT continues straight into
    // the next window if Enable is still high, otherwise drops to IDLE.
    always_comb begin
        state_next = state;
        Busy       = 1'b0;
        case (state)
            IDLE: begin
                if (Enable) begin
                    state_next = COUNT;
                end
            end
            COUNT: begin
                Busy = 1'b1;
                if (!Enable) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge SysClock) begin
        if (Reset) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            gate_cnt  <= '0;
            edge_cnt  <= '0;
            sticky    <= 1'b0;
            Frequency <= '0;
            Overflow  <= 1'b0;
            Valid     <= 1'b0;
        end else begin
            s1    <= SignalIn;
            s2    <= s1;
            s3    <= s2;
            Valid <= 1'b0;

            if (state == COUNT) begin
                if (window_end) begin
                    // The edge seen in the last gate cycle still belongs to
                    // this window; the next window starts with no dead cycle.
                    Frequency <= edge_cnt_next;
                    Overflow  <= sticky_next;
                    Valid     <= 1'b1;
                    gate_cnt  <= '0;
                    edge_cnt  <= '0;
                    sticky    <= 1'b0;
                end else if (!Enable) begin
                    // Partial window is discarded.
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    sticky   <= 1'b0;
                end else begin
                    gate_cnt <= gate_cnt + 1'b1;
                    edge_cnt <= edge_cnt_next;
                    sticky   <= sticky_next;
                end
            end else begin
                gate_cnt <= '0;
                edge_cnt <= '0;
                sticky   <= 1'b0;
            end
        end
    end

endmodule

// File: doc/frequency_meter.md
Name: frequency_meter

Overview:
Measures the frequency of an asynchronous digital input by counting its rising edges over a fixed gate window of SysClock cycles. It is the inverse of the clock divider: that block derives known slow ticks from SysClock, and this block recovers an unknown rate against SysClock. It feeds display/readout logic with a held count, a one-cycle Valid strobe per window and an Overflow flag. Windows run back-to-back while Enable is high.

Parameters:
GATE_CYCLES  50_000_000  gate window length in SysClock cycles; >= 4; one window = 1 s at 50 MHz.
COUNT_W  24  width of the edge counter and the Frequency output.
GATE_W  $clog2(GATE_CYCLES)  derived width of the gate counter; not overridden.

Ports:
SysClock  input  1  sole clock; all logic on its rising edge.
Reset  input  1  synchronous, active-high; clears all state.
Enable  input  1  level; high runs continuous windows, low returns the block to IDLE.
SignalIn  input  1  asynchronous signal under measurement.
Frequency  output  COUNT_W  rising-edge count of the last completed window; held between windows.
Valid  output  1  one-cycle pulse when Frequency and Overflow update.
Overflow  output  1  1 when the last completed window's count saturated; updates with Frequency.
Busy  output  1  1 while in COUNT state.

Behaviour:
- Reset (synchronous): state=IDLE; gate counter, edge counter, Frequency, Overflow, Valid, Busy, and all three synchroniser/edge flops reset to 0.
- Input path:
  - SignalIn passes through two synchroniser flops (s1, s2) into an edge register s3.
  - edge = s2 & ~s3.
  - Latency from a SignalIn rise to edge is 3 SysClock cycles.
  - Edge detection runs in every state.
  - If SignalIn is high at reset release, one edge results; it is counted only if the block is in COUNT at that cycle.
- IDLE:
  - Busy=0; counters held at 0.
  - If Enable=1 is sampled in IDLE, go to COUNT on the next cycle with gate=0 and edges=0.
- COUNT:
  - Busy=1; gate increments every cycle.
  - On edge, edges increments, saturating at 2^COUNT_W-1; a sticky window-overflow bit sets when an increment is attempted at max.
- Window end (COUNT cycle with gate==GATE_CYCLES-1):
  - The edge in that cycle is included.
  - Next cycle: Frequency <= final edges; Overflow <= final sticky bit; Valid=1 for exactly one cycle.
  - In the same transition, gate, edges and the sticky bit clear and a new window starts. There is no dead cycle, so windows tile exactly GATE_CYCLES cycles apart.
  - Valid therefore first rises GATE_CYCLES+1 cycles after the cycle Enable was sampled high in IDLE, then every GATE_CYCLES cycles.
- Enable low sampled in COUNT:
  - Go to IDLE next cycle; the partial window is discarded.
  - No Valid; Frequency and Overflow keep their last completed values.
  - If this coincides with window end, the window completes (Valid fires) and the next state is IDLE.
- Reset mid-window overrides everything: state as at reset; Frequency cleared; no Valid.
- Arithmetic:
  - Unsigned.
  - Gate counter compares against GATE_CYCLES-1 at GATE_W bits.
  - Maximum countable rate is SysClock/2. Above that, edges alias and no error is flagged.
- Edges falling within the final 3 cycles of a window, relative to SignalIn, are counted in the next window through pipeline delay. The long-run count is exact; a single window is accurate to ±1.

Test Plan (GATE_CYCLES=100, COUNT_W=8 unless noted):
1. Reset held 3 cycles with SignalIn toggling -> Frequency=0, Valid=0, Overflow=0, Busy=0 throughout; Busy=0 after release while Enable=0.
2. Enable=1, SignalIn period 10 cycles (any phase) -> first Valid 101 cycles after Enable is sampled, then every 100 cycles; Frequency=10 each window; Overflow=0; Valid exactly 1 cycle wide.
3. COUNT_W=4, SignalIn period 4 -> Frequency=15, Overflow=1 each window; switch to period 10 -> next full window gives Frequency=10, Overflow=0.
4. After one window reporting 10, drop Enable 50 cycles into the next window -> no Valid, Frequency holds 10, Busy=0; re-raise Enable -> Valid 101 cycles later with Frequency=10.
5. SignalIn constant low, then constant high -> Valid every 100 cycles with Frequency=0 (no spurious edges from constant high after the first window).
6. Assert Reset 60 cycles into a window with Frequency=10 -> next cycle Frequency=0, Busy=0, no Valid; after release with Enable=1 -> a full fresh window of 100 cycles before the first Valid.
